// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the pc_sequencer fetch/issue/resolve loop.
// Resolve encodings, FSM states and the default reset PC live here.
package pc_sequencer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RES_SEQ    = 2'b00,
        RES_BRANCH = 2'b01,
        RES_JUMP   = 2'b10,
        RES_JR     = 2'b11
    } resolve_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_RESOLVE
    } state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC computation: sequential address, control-flow target,
// whether the outcome leaves the sequential path, and jr misalignment.
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] instr_pc,
    input  resolve_type_e   resolve_type,
    input  logic [15:0]     branch_off,
    input  logic [25:0]     jump_index,
    input  logic [XLEN-1:0] jr_target,
    output logic [XLEN-1:0] seq_pc,
    output logic [XLEN-1:0] target_pc,
    output logic            taken,
    output logic            misalign
);

    logic [XLEN-1:0] branch_delta;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        seq_pc       = instr_pc + 32'd4;
        branch_delta = {{14{branch_off[15]}}, branch_off, 2'b00};
        target_pc    = seq_pc;
        taken        = 1'b0;
        misalign     = 1'b0;
        case (resolve_type)
            RES_SEQ: begin
                target_pc = seq_pc;
            end
            RES_BRANCH: begin
                target_pc = seq_pc + branch_delta;
                taken     = 1'b1;
            end
            RES_JUMP: begin
                target_pc = {seq_pc[31:28], jump_index, 2'b00};
                taken     = 1'b1;
            end
            RES_JR: begin
                target_pc = word_align(jr_target);
                taken     = 1'b1;
                misalign  = |jr_target[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch, issue to decode, wait for resolve, repeat.
// Optional branch delay slot behaviour is enabled with SEQ_DELAY_SLOT_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            resolve_valid,
    input  logic [1:0]      resolve_type,
    input  logic [15:0]     branch_off,
    input  logic [25:0]     jump_index,
    input  logic [XLEN-1:0] jr_target,
    output logic            misalign_err
);

    state_e          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target_pc;
    logic            taken;
    logic            misalign;
    logic [XLEN-1:0] next_pc;

    pc_target_calc u_calc (
        .instr_pc     (instr_pc),
        .resolve_type (resolve_type_e'(resolve_type)),
        .branch_off   (branch_off),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .seq_pc       (seq_pc),
        .target_pc    (target_pc),
        .taken        (taken),
        .misalign     (misalign)
    );

`ifdef SEQ_DELAY_SLOT_EN
    logic            pending_valid;
    logic [XLEN-1:0] pending_pc;

    // The slot after a taken outcome always runs sequentially; its own outcome is dropped.
    always_comb begin
        next_pc = pending_valid ? pending_pc : seq_pc;
    end
`else
    always_comb begin
        next_pc = taken ? target_pc : seq_pc;
    end
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
`ifdef SEQ_DELAY_SLOT_EN
            pending_valid <= 1'b0;
            pending_pc    <= '0;
`endif
        end else begin
            misalign_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state     <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (resolve_valid) begin
                        pc           <= next_pc;
                        imem_addr    <= next_pc;
                        imem_req     <= 1'b1;
                        misalign_err <= misalign;
                        state        <= ST_FETCH;
`ifdef SEQ_DELAY_SLOT_EN
                        if (pending_valid) begin
                            pending_valid <= 1'b0;
                        end else if (taken) begin
                            pending_valid <= 1'b1;
                            pending_pc    <= target_pc;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
